// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and constants for the configurable TX/RX pair
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int MIN_DATA_BITS      = 5;
    localparam int MAX_DATA_BITS      = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // The reserved code 2'b11 falls back to no parity.
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg, input int max_bits);
        if (int'(cfg) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
        if (int'(cfg) > max_bits)      return 4'(max_bits);
        return cfg;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter (5-9 data bits, parity, 1/2 stop)
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int MAX_DATA   = MAX_DATA_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_tick,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [MAX_DATA-1:0] s_data,
    input  logic [3:0]          cfg_data_bits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int              CNT_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    uart_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic [3:0]          nbits_q, nbits_d;
    logic [MAX_DATA-1:0] shift_q, shift_d;
    parity_e             par_mode_q, par_mode_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                stop_idx_q, stop_idx_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic                accept;
    logic                bit_end;
    logic [3:0]          nbits_acc;
    parity_e             par_acc;
    logic [MAX_DATA-1:0] data_masked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= '0;
            shift_q    <= '0;
            par_mode_q <= PAR_NONE;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            nbits_q    <= nbits_d;
            shift_q    <= shift_d;
            par_mode_q <= par_mode_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        accept      = s_valid && (state_q == ST_IDLE) && !rst;
        bit_end     = baud_tick && (cnt_q == CNT_LAST);
        nbits_acc   = clamp_data_bits(cfg_data_bits, MAX_DATA);
        par_acc     = decode_parity(cfg_parity);
        data_masked = '0;
        for (int i = 0; i < MAX_DATA; i++) begin
            if (i < int'(nbits_acc)) data_masked[i] = s_data[i];
        end

        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        nbits_d    = nbits_q;
        shift_d    = shift_q;
        par_mode_d = par_mode_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        done_d     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (accept) begin
                state_d    = ST_START;
                cnt_d      = '0;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                nbits_d    = nbits_acc;
                shift_d    = data_masked;
                par_mode_d = par_acc;
                par_bit_d  = (^data_masked) ^ (par_acc == PAR_ODD);
                stop2_d    = cfg_stop2;
            end
        end else if (baud_tick) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        if (bit_end) begin
            case (state_q)
                ST_START: state_d = ST_DATA;
                ST_DATA: begin
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d = (par_mode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    // Two stop bits count whole bit periods rather than stretching the timer.
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_ready = (state_q == ST_IDLE) && !rst;
        busy    = (state_q != ST_IDLE);
        tx      = tx_q;
        done    = done_q;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed vector bench for uart_tx_cfg
module tb_uart_tx_cfg;

    localparam int OS   = 16;
    localparam int HIST = 1500;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       s_valid;
    logic       s_ready;
    logic [8:0] s_data;
    logic [3:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;

    logic tick_sparse = 1'b0;
    int   tick_cnt    = 0;

    logic tx_hist   [0:HIST-1];
    logic busy_hist [0:HIST-1];

    typedef struct {
        logic [8:0]  data;
        logic [3:0]  bits;
        logic [1:0]  par;
        logic        stop2;
        logic [12:0] frame;
        int          len;
    } vec_t;

    vec_t vecs [8];

    uart_tx_cfg #(.OVERSAMPLE(OS), .MAX_DATA(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx            (tx),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!tick_sparse) begin
            baud_tick = 1'b1;
        end else begin
            tick_cnt  = (tick_cnt + 1) % 4;
            baud_tick = (tick_cnt == 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Sends one frame with baud_tick=1 and compares every cycle of tx against the expected bit list.
    task automatic run_frame(input vec_t v, input string tag);
        int errs, busy_n, done_n, done_at;
        @(negedge clk);
        check({tag, "_ready"}, int'(s_ready), 1);
        s_valid       = 1'b1;
        s_data        = v.data;
        cfg_data_bits = v.bits;
        cfg_parity    = v.par;
        cfg_stop2     = v.stop2;
        @(posedge clk); #1;
        s_valid       = 1'b0;
        s_data        = ~v.data;
        cfg_data_bits = ~v.bits;
        cfg_parity    = ~v.par;
        cfg_stop2     = ~v.stop2;
        errs = 0; busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 1; c <= OS * v.len + 3; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c <= OS * v.len && tx !== v.frame[(c - 1) / OS]) errs++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        check({tag, "_tx_wave_errs"}, errs, 0);
        check({tag, "_busy_cycles"}, busy_n, OS * v.len);
        check({tag, "_done_cycle"}, done_at, OS * v.len + 1);
        check({tag, "_done_pulses"}, done_n, 1);
    endtask

    // 8N1 data decode counting back from the done cycle; bits after start are exactly 64 cycles.
    function automatic int decode8(input int d);
        int val;
        if (d < 600 || d >= HIST) return -1;
        val = 0;
        for (int k = 0; k < 8; k++) begin
            if (tx_hist[d - 64 * (9 - k) + 32]) val = val | (1 << k);
        end
        return val;
    endfunction

    initial begin
        int d1, d2, len1, len2, bad, dn;
        vec_t vb;

        vecs[0] = '{9'h055, 4'd8,  2'b00, 1'b0, 13'h2AA, 10};
        vecs[1] = '{9'h041, 4'd7,  2'b01, 1'b0, 13'h282, 10};
        vecs[2] = '{9'h043, 4'd7,  2'b00, 1'b0, 13'h186, 9};
        vecs[3] = '{9'h000, 4'd8,  2'b10, 1'b1, 13'hE00, 12};
        vecs[4] = '{9'h1FF, 4'd9,  2'b00, 1'b0, 13'h7FE, 11};
        vecs[5] = '{9'h01F, 4'd3,  2'b00, 1'b0, 13'h07E, 7};
        vecs[6] = '{9'h1E3, 4'd5,  2'b01, 1'b1, 13'h186, 9};
        vecs[7] = '{9'h0A5, 4'd8,  2'b11, 1'b0, 13'h34A, 10};

        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ready", int'(s_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_ready", int'(s_ready), 1);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back frames with sparse ticks and s_valid held.
        tick_sparse = 1'b1;
        @(negedge clk);
        s_valid = 1'b1; s_data = 9'h0A5;
        cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        @(posedge clk); #1;
        d1 = -1; d2 = -1;
        for (int c = 1; c < HIST; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            tx_hist[c]   = tx;
            busy_hist[c] = busy;
            if (c == 1) s_data = 9'h03C;
            if (done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (d1 > 0 && c == d1 + 1) begin
                s_valid = 1'b0;
                s_data  = 9'h0FF;
            end
            if (d2 > 0 && c >= d2 + 1) break;
        end
        check("b2b_first_done_seen", int'(d1 > 0), 1);
        check("b2b_second_done_seen", int'(d2 > 0), 1);
        if (d1 > 0 && d2 > 0) begin
            len1 = d1 - 577;
            len2 = d2 - 577 - d1;
            check("b2b_frame1_data", decode8(d1), 32'hA5);
            check("b2b_frame2_data", decode8(d2), 32'h3C);
            check("b2b_frame1_stop", int'(tx_hist[d1 - 32]), 1);
            check("b2b_frame1_start_low", int'(tx_hist[1]), 0);
            check("b2b_start1_len_in_range", int'(len1 >= 60 && len1 <= 64), 1);
            check("b2b_start2_len_in_range", int'(len2 >= 60 && len2 <= 64), 1);
            check("b2b_busy_at_done", int'(busy_hist[d1]), 0);
            check("b2b_start2_tx", int'(tx_hist[d1 + 1]), 0);
            check("b2b_start2_busy", int'(busy_hist[d1 + 1]), 1);
        end
        tick_sparse = 1'b0;

        // Reset during data bit 3 (cycles 65..80 with tick=1).
        @(negedge clk);
        s_valid = 1'b1; s_data = 9'h052;
        cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        check("abort_pre_tx_bit3", int'(tx), 0);
        check("abort_pre_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ready_in_reset", int'(s_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0; dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) dn++;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_no_done_after", dn, 0);
        check("abort_idle_after", bad, 0);
        vb = '{9'h096, 4'd8, 2'b01, 1'b0, 13'h52C, 11};
        run_frame(vb, "after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
